// File: rtl/consumatore_multicanale_pkg.sv
// Shared definitions for the multi-channel dav_/rfd consumer: FSM encoding
// and the channel-index width helper.
package consumatore_multicanale_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_WAIT  = 2'd2
  } star_t;

  // Channel index width; never narrower than one bit.
  function automatic int unsigned cw_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arbitro_rr.sv
// Combinational round-robin arbiter: first requester after last_ptr wins.
module arbitro_rr
  import consumatore_multicanale_pkg::*;
#(
  parameter int unsigned N_CH = 2,
  parameter int unsigned CW   = cw_of(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CW-1:0]   last_ptr,
  output logic [CW-1:0]   winner,
  output logic            valid
);

  logic [CW-1:0] idx;

  // Scan last_ptr+1 .. last_ptr+N_CH, wrapping, so last_ptr itself comes last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      idx = CW'((32'(last_ptr) + k) % N_CH);
      if (!valid && req[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/consumatore_multicanale.sv
// N_CH-channel dav_/rfd consumer: round-robin picks a producer, then out is
// held high for exactly that producer's numero cycles.
module consumatore_multicanale
  import consumatore_multicanale_pkg::*;
#(
  parameter int unsigned N_CH = 2,
  parameter int unsigned W    = 8,
  parameter int unsigned CW   = cw_of(N_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_CH-1:0]   dav_,
  input  logic [N_CH*W-1:0] numero,
  output logic [N_CH-1:0]   rfd,
  output logic              out,
  output logic [CW-1:0]     ch_attivo,
  output logic              busy
);

  star_t           star_q, star_d;
  logic [W-1:0]    count_q, count_d;
  logic [CW-1:0]   last_q, last_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [N_CH-1:0] rfd_q, rfd_d;
  logic            out_q, out_d;
  logic            busy_q, busy_d;

  logic [CW-1:0]   winner;
  logic            win_valid;
  logic [W-1:0]    num_arr [N_CH];

  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      num_arr[i] = numero[i*W +: W];
    end
  end

  arbitro_rr #(
    .N_CH (N_CH),
    .CW   (CW)
  ) u_arbitro (
    .req      (~dav_),
    .last_ptr (last_q),
    .winner   (winner),
    .valid    (win_valid)
  );

  // Next-state and registered-output logic.
  always_comb begin
    star_d  = star_q;
    count_d = count_q;
    last_d  = last_q;
    ch_d    = ch_q;
    rfd_d   = rfd_q;
    out_d   = out_q;
    busy_d  = busy_q;
    case (star_q)
      S_IDLE: begin
        rfd_d  = '1;
        out_d  = 1'b0;
        busy_d = 1'b0;
        if (win_valid) begin
          ch_d    = winner;
          last_d  = winner;
          count_d = num_arr[winner];
          rfd_d   = '0;
          busy_d  = 1'b1;
          // A zero word skips counting entirely so the counter never underflows.
          if (num_arr[winner] != '0) begin
            out_d  = 1'b1;
            star_d = S_COUNT;
          end else begin
            star_d = S_WAIT;
          end
        end
      end
      S_COUNT: begin
        count_d = count_q - W'(1);
        if (count_q == W'(1)) begin
          out_d  = 1'b0;
          star_d = S_WAIT;
        end
      end
      S_WAIT: begin
        out_d = 1'b0;
        rfd_d = '0;
        if (dav_[ch_q]) begin
          star_d = S_IDLE;
          rfd_d  = '1;
          busy_d = 1'b0;
        end
      end
      default: begin
        star_d = S_IDLE;
        rfd_d  = '1;
        out_d  = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      star_q  <= S_IDLE;
      count_q <= '0;
      last_q  <= CW'(N_CH - 1);
      ch_q    <= '0;
      rfd_q   <= '1;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      star_q  <= star_d;
      count_q <= count_d;
      last_q  <= last_d;
      ch_q    <= ch_d;
      rfd_q   <= rfd_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign rfd       = rfd_q;
  assign out       = out_q;
  assign ch_attivo = ch_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_consumatore_multicanale.sv
// Scoreboard bench: stimulus queues expected services (channel, pulse length),
// per-DUT monitors measure each service and compare when busy drops.
module tb_consumatore_multicanale;

  typedef struct {
    int ch;
    int len;
  } svc_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  dav2 = 2'b11;
  logic [15:0] num2 = '0;
  logic [1:0]  rfd2;
  logic        out2;
  logic [0:0]  ch2;
  logic        busy2;
  logic [3:0]  dav4 = 4'hF;
  logic [31:0] num4 = '0;
  logic [3:0]  rfd4;
  logic        out4;
  logic [1:0]  ch4;
  logic        busy4;

  int checks = 0;
  int errors = 0;
  svc_t exp2[$];
  svc_t exp4[$];

  always #5 clock = ~clock;

  consumatore_multicanale #(.N_CH(2), .W(8)) u_dut2 (
    .clock(clock), .reset(reset), .dav_(dav2), .numero(num2),
    .rfd(rfd2), .out(out2), .ch_attivo(ch2), .busy(busy2)
  );

  consumatore_multicanale #(.N_CH(4), .W(8)) u_dut4 (
    .clock(clock), .reset(reset), .dav_(dav4), .numero(num4),
    .rfd(rfd4), .out(out4), .ch_attivo(ch4), .busy(busy4)
  );

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Monitor for the 2-channel DUT.
  logic m2_in = 1'b0;
  logic m2_bad = 1'b0;
  int   m2_ch = 0;
  int   m2_len = 0;
  svc_t m2_e;
  always @(negedge clock) begin
    if (reset) begin
      m2_in = 1'b0;
    end else if (busy2) begin
      if (!m2_in) begin
        m2_in = 1'b1; m2_ch = int'(ch2); m2_len = 0; m2_bad = 1'b0;
      end
      if (out2) m2_len++;
      if (rfd2 != 2'b00) m2_bad = 1'b1;
    end else if (m2_in) begin
      m2_in = 1'b0;
      if (exp2.size() == 0) begin
        chk("dut2_unexpected_service", 1, 0);
      end else begin
        m2_e = exp2.pop_front();
        chk("dut2_channel", m2_ch, m2_e.ch);
        chk("dut2_pulse_len", m2_len, m2_e.len);
        chk("dut2_rfd_low_while_busy", int'(m2_bad), 0);
        chk("dut2_rfd_after_service", int'(rfd2), 3);
      end
    end
  end

  // Monitor for the 4-channel DUT.
  logic m4_in = 1'b0;
  logic m4_bad = 1'b0;
  int   m4_ch = 0;
  int   m4_len = 0;
  svc_t m4_e;
  always @(negedge clock) begin
    if (reset) begin
      m4_in = 1'b0;
    end else if (busy4) begin
      if (!m4_in) begin
        m4_in = 1'b1; m4_ch = int'(ch4); m4_len = 0; m4_bad = 1'b0;
      end
      if (out4) m4_len++;
      if (rfd4 != 4'h0) m4_bad = 1'b1;
    end else if (m4_in) begin
      m4_in = 1'b0;
      if (exp4.size() == 0) begin
        chk("dut4_unexpected_service", 1, 0);
      end else begin
        m4_e = exp4.pop_front();
        chk("dut4_channel", m4_ch, m4_e.ch);
        chk("dut4_pulse_len", m4_len, m4_e.len);
        chk("dut4_rfd_low_while_busy", int'(m4_bad), 0);
        chk("dut4_rfd_after_service", int'(rfd4), 15);
      end
    end
  end

  // Producer side for DUT2: on each grant, release the winner's dav_.
  task automatic serve2(input int n);
    int t;
    for (int s = 0; s < n; s++) begin
      t = 0;
      while (!busy2 && t < 600) begin @(negedge clock); t++; end
      if (!busy2) begin chk("dut2_grant_timeout", 0, 1); return; end
      dav2[ch2] = 1'b1;
      t = 0;
      while (busy2 && t < 600) begin @(negedge clock); t++; end
      if (busy2) begin chk("dut2_done_timeout", 0, 1); return; end
    end
  endtask

  task automatic push2(input int c, input int l);
    svc_t e;
    e.ch = c; e.len = l;
    exp2.push_back(e);
  endtask

  task automatic push4(input int c, input int l);
    svc_t e;
    e.ch = c; e.len = l;
    exp4.push_back(e);
  endtask

  initial begin
    int t;
    int c;
    repeat (2) @(negedge clock);
    chk("reset_out", int'(out2), 0);
    chk("reset_rfd2", int'(rfd2), 3);
    chk("reset_busy", int'(busy2), 0);
    chk("reset_ch_attivo", int'(ch2), 0);
    chk("reset_rfd4", int'(rfd4), 15);
    reset = 1'b0;
    @(negedge clock);

    // Single request, ch0, numero=3.
    num2[7:0] = 8'd3;
    push2(0, 3);
    dav2[0] = 1'b0;
    serve2(1);
    chk("single_rfd_idle", int'(rfd2), 3);
    chk("single_ch_attivo", int'(ch2), 0);
    @(negedge clock);

    // numero=0 on ch1: no pulse, stays busy until dav_ released.
    num2[15:8] = 8'd0;
    push2(1, 0);
    dav2[1] = 1'b0;
    repeat (6) @(negedge clock);
    chk("zero_busy_held", int'(busy2), 1);
    chk("zero_out_low", int'(out2), 0);
    chk("zero_rfd_low", int'(rfd2), 0);
    chk("zero_ch_attivo", int'(ch2), 1);
    serve2(1);
    chk("zero_rfd_idle", int'(rfd2), 3);
    @(negedge clock);

    // Simultaneous requests right after reset: ch0 then ch1.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    num2 = {8'd4, 8'd2};
    push2(0, 2);
    push2(1, 4);
    dav2 = 2'b00;
    serve2(2);
    @(negedge clock);

    // Maximum word: 255-cycle pulse.
    num2[15:8] = 8'hFF;
    push2(1, 255);
    dav2[1] = 1'b0;
    serve2(1);
    @(negedge clock);

    // Fairness on 4 channels with every producer re-requesting at once.
    num4 = {8'd4, 8'd3, 8'd2, 8'd1};
    push4(0, 1); push4(1, 2); push4(2, 3); push4(3, 4); push4(0, 1);
    dav4 = 4'h0;
    for (int s = 0; s < 5; s++) begin
      t = 0;
      while (!busy4 && t < 100) begin @(negedge clock); t++; end
      if (!busy4) begin chk("dut4_grant_timeout", 0, 1); break; end
      c = int'(ch4);
      if (s == 4) dav4 = 4'hF;
      else dav4[c] = 1'b1;
      t = 0;
      while (busy4 && t < 100) begin @(negedge clock); t++; end
      if (busy4) begin chk("dut4_done_timeout", 0, 1); break; end
      if (s < 4) dav4[c] = 1'b0;
    end
    dav4 = 4'hF;
    repeat (3) @(negedge clock);
    chk("dut4_idle_after_fairness", int'(busy4), 0);

    // Asynchronous reset in the middle of a 5-cycle pulse.
    num2[7:0] = 8'd5;
    dav2[0] = 1'b0;
    t = 0;
    while (!busy2 && t < 20) begin @(negedge clock); t++; end
    chk("midreset_started", int'(busy2), 1);
    @(negedge clock);
    chk("midreset_out_before", int'(out2), 1);
    #2 reset = 1'b1;
    #1;
    chk("midreset_out", int'(out2), 0);
    chk("midreset_rfd", int'(rfd2), 3);
    chk("midreset_busy", int'(busy2), 0);
    dav2 = 2'b11;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("midreset_stays_idle", int'(busy2), 0);

    chk("dut2_queue_drained", exp2.size(), 0);
    chk("dut4_queue_drained", exp4.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
